// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length byte and a little-endian byte
// stream from a host, fills a 128-word memory, then releases the processor.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, processor held in reset, no bytes accepted
// LEN   | waiting for the length byte (0 or >128 means 128 words)
// LOAD  | assembling bytes into words and writing them to memory
// DONE  | program loaded, processor released, new start reloads
module imem_loader #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   output logic         byte_ready,
   input  logic [6:0]   addr,
   output logic [N-1:0] q,
   output logic         cpu_reset,
   output logic         busy,
   output logic         done,
   output logic [7:0]   word_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LEN  = 2'd1,
      S_LOAD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [1:0]   lane_q, lane_d;
   logic [6:0]   waddr_q, waddr_d;
   logic [7:0]   wcnt_q, wcnt_d;
   logic [7:0]   len_q, len_d;
   logic [23:0]  part_q, part_d;
   logic         accept;
   logic         wr_en;
   logic [31:0]  wr_word;
   logic [N-1:0] mem [128];

   assign accept  = byte_valid && byte_ready;
   // The fourth byte goes straight into the top lane of the written word.
   assign wr_word = {byte_data, part_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         lane_q  <= 2'd0;
         waddr_q <= 7'd0;
         wcnt_q  <= 8'd0;
         len_q   <= 8'd0;
         part_q  <= 24'd0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         waddr_q <= waddr_d;
         wcnt_q  <= wcnt_d;
         len_q   <= len_d;
         part_q  <= part_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      waddr_d    = waddr_q;
      wcnt_d     = wcnt_q;
      len_d      = len_q;
      part_d     = part_q;
      wr_en      = 1'b0;
      byte_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      cpu_reset  = 1'b1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               done      = 1'b1;
               cpu_reset = 1'b0;
            end
            if (start) begin
               state_d = S_LEN;
               lane_d  = 2'd0;
               waddr_d = 7'd0;
               wcnt_d  = 8'd0;
               part_d  = 24'd0;
            end
         end
         S_LEN: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (accept) begin
               state_d = S_LOAD;
               if (byte_data == 8'd0 || byte_data > 8'd128)
                  len_d = 8'd128;
               else
                  len_d = byte_data;
            end
         end
         S_LOAD: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (accept) begin
               lane_d = lane_q + 2'd1;
               case (lane_q)
                  2'd0: part_d[7:0]   = byte_data;
                  2'd1: part_d[15:8]  = byte_data;
                  2'd2: part_d[23:16] = byte_data;
                  default: begin
                     wr_en   = 1'b1;
                     waddr_d = waddr_q + 7'd1;
                     wcnt_d  = wcnt_q + 8'd1;
                     if (wcnt_d == len_q)
                        state_d = S_DONE;
                  end
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++)
            mem[i] <= '0;
      end else if (wr_en) begin
         mem[waddr_q] <= N'(wr_word);
      end
   end

   assign q          = mem[addr];
   assign word_count = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, two-word load, reload with ignored
// start, length saturation, handshake gaps and mid-load reset.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic [6:0]  addr = 7'd0;
   logic [31:0] q;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic [7:0]  word_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_mem [128];

   imem_loader #(.N(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .addr       (addr),
      .q          (q),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      waited = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && waited < 50) begin
         tick(1);
         waited++;
      end
      if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
      tick(1);
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      if (gap > 0) tick(gap);
   endtask

   task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, q, exp);
   endtask

   initial begin
      // reset and IDLE behaviour
      tick(1);
      reset = 1'b0;
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_cpu_reset",  32'(cpu_reset),  32'd1);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_done",       32'(done),       32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      rd("rst_q0",   7'd0,   32'h0);
      rd("rst_q63",  7'd63,  32'h0);
      rd("rst_q127", 7'd127, 32'h0);
      byte_valid = 1'b1;
      byte_data  = 8'haa;
      tick(3);
      chk("idle_no_ready", 32'(byte_ready), 32'd0);
      chk("idle_no_count", 32'(word_count), 32'd0);
      byte_valid = 1'b0;

      // two-word load
      pulse_start();
      chk("len_ready", 32'(byte_ready), 32'd1);
      chk("len_busy",  32'(busy),       32'd1);
      send_byte(8'h02, 0);
      send_byte(8'he4, 0); send_byte(8'h03, 0); send_byte(8'h01, 0); send_byte(8'h8b, 0);
      send_byte(8'he0, 0); send_byte(8'h03, 0); send_byte(8'h1f, 0);
      chk("pre_last_done", 32'(done), 32'd0);
      send_byte(8'h8b, 0);
      chk("two_done",      32'(done),       32'd1);
      chk("two_cpu_reset", 32'(cpu_reset),  32'd0);
      chk("two_count",     32'(word_count), 32'd2);
      chk("two_busy",      32'(busy),       32'd0);
      rd("two_m0", 7'd0, 32'h8b0103e4);
      rd("two_m1", 7'd1, 32'h8b1f03e0);
      rd("two_m2", 7'd2, 32'h0);

      // bytes in DONE are not accepted
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      tick(3);
      chk("done_no_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b0;
      rd("done_m0_kept", 7'd0, 32'h8b0103e4);

      // reload length 1 with start pulsed mid-LOAD
      pulse_start();
      chk("reload_clear_count", 32'(word_count), 32'd0);
      send_byte(8'h01, 0);
      send_byte(8'hff, 0); send_byte(8'h03, 0);
      pulse_start();
      chk("mid_start_busy", 32'(busy), 32'd1);
      send_byte(8'h1f, 0); send_byte(8'h8b, 0);
      chk("reload_done",  32'(done),       32'd1);
      chk("reload_count", 32'(word_count), 32'd1);
      rd("reload_m0", 7'd0, 32'h8b1f03ff);
      rd("reload_m1", 7'd1, 32'h8b1f03e0);

      // same two-word program with idle gaps between bytes
      pulse_start();
      send_byte(8'h02, 2);
      send_byte(8'he4, 1); send_byte(8'h03, 3); send_byte(8'h01, 0); send_byte(8'h8b, 2);
      send_byte(8'he0, 0); send_byte(8'h03, 4); send_byte(8'h1f, 1);
      send_byte(8'h8b, 0);
      chk("gap_done",  32'(done),       32'd1);
      chk("gap_count", 32'(word_count), 32'd2);
      rd("gap_m0", 7'd0, 32'h8b0103e4);
      rd("gap_m1", 7'd1, 32'h8b1f03e0);

      // length saturation: 00 and c8 both load 128 words
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 512; i++) begin
            logic [7:0] b;
            b = 8'((i * (7 + 2 * pass)) + 3 + pass);
            exp_mem[i / 4][8 * (i % 4) +: 8] = b;
         end
         pulse_start();
         send_byte(pass == 0 ? 8'h00 : 8'hc8, 0);
         for (int i = 0; i < 512; i++) begin
            send_byte(8'((i * (7 + 2 * pass)) + 3 + pass), 0);
            if (i == 507) begin
               chk("sat_count127", 32'(word_count), 32'd127);
               chk("sat_not_done", 32'(done),       32'd0);
            end
         end
         chk("sat_done",  32'(done),       32'd1);
         chk("sat_count", 32'(word_count), 32'd128);
         for (int a = 0; a < 128; a++)
            rd("sat_mem", 7'(a), exp_mem[a]);
      end

      // write address wrapped to 0: a one-word reload lands at word 0
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
      rd("wrap_m0", 7'd0, 32'h44332211);
      rd("wrap_m1", 7'd1, exp_mem[1]);

      // mid-load reset after 6 bytes
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'he4, 0); send_byte(8'h03, 0); send_byte(8'h01, 0); send_byte(8'h8b, 0);
      send_byte(8'he0, 0);
      rd("pre_rst_m0", 7'd0, 32'h8b0103e4);
      pulse_reset();
      chk("mrst_busy",      32'(busy),       32'd0);
      chk("mrst_cpu_reset", 32'(cpu_reset),  32'd1);
      chk("mrst_count",     32'(word_count), 32'd0);
      rd("mrst_m0", 7'd0, 32'h0);
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      tick(3);
      chk("mrst_no_ready", 32'(byte_ready), 32'd0);
      chk("mrst_no_count", 32'(word_count), 32'd0);
      byte_valid = 1'b0;
      rd("mrst_m1", 7'd1, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
